// File: rtl/led_sequencer.sv
// ---------------------------------------------------------------------------
// LedSequencer -- walks a single lit position across N_OUT one-hot outputs.
//
// A free-running prescaler produces an automatic advance every DIV enabled
// clock cycles. A rising edge on the manual step input also requests an
// advance, and a rollover and a step edge in the same cycle merge into one.
// On each advance the position moves up, down or ping-pong, or stays put
// (hold), depending on mode.
//
// Parameters
//   N_OUT       number of one-hot outputs (1..256)
//   DIV         clock cycles per automatic step (>= 1)
//   ACTIVE_LOW  1 inverts every bit of out
//
// Ports
//   clk   in   single clock, rising edge
//   rst   in   synchronous active-high reset
//   en    in   prescaler run enable
//   mode  in   00 up, 01 down, 10 ping-pong, 11 hold
//   step  in   manual advance request (level, rising edge detected here)
//   out   out  one-hot of pos, polarity set by ACTIVE_LOW
//   pos   out  current position index
//   tick  out  one-cycle pulse on each prescaler rollover
//   wrap  out  one-cycle pulse when a full sequence cycle completes
// ---------------------------------------------------------------------------
module led_sequencer #(
   parameter int N_OUT      = 8,
   parameter int DIV        = 12000000,
   parameter int ACTIVE_LOW = 0
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   en,
   input  logic [1:0]                             mode,
   input  logic                                   step,
   output logic [N_OUT-1:0]                       out,
   output logic [(N_OUT > 1 ? $clog2(N_OUT) : 1)-1:0] pos,
   output logic                                   tick,
   output logic                                   wrap
);

   localparam int PW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [PW-1:0]    LAST     = PW'(N_OUT - 1);
   localparam logic [CW-1:0]    PRESC_TOP = CW'(DIV - 1);
   localparam logic             POL      = (ACTIVE_LOW != 0);
   localparam logic [N_OUT-1:0] ONE      = N_OUT'(1);
   localparam logic [N_OUT-1:0] RESET_OUT = POL ? ~ONE : ONE;

   // Refuse to build with parameter values outside their legal ranges.
   generate
      if (N_OUT < 1 || N_OUT > 256) begin : gBadNOut
         $error("led_sequencer: N_OUT must be in 1..256");
      end
      if (DIV < 1) begin : gBadDiv
         $error("led_sequencer: DIV must be >= 1");
      end
      if (ACTIVE_LOW != 0 && ACTIVE_LOW != 1) begin : gBadPol
         $error("led_sequencer: ACTIVE_LOW must be 0 or 1");
      end
   endgenerate

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dirT;

   logic [CW-1:0]    r_presc;
   logic             r_stepPrev;
   dirT              r_dir;
   logic [PW-1:0]    r_pos;
   logic [N_OUT-1:0] r_out;
   logic             r_tick;
   logic             r_wrap;

   logic             w_rollover;
   logic             w_stepEdge;
   logic             w_advance;
   logic [PW-1:0]    w_posNext;
   dirT              w_dirNext;
   logic             w_wrapNext;
   logic             w_moveUp;
   logic [N_OUT-1:0] w_outNext;

   // A rollover and a step edge are OR-ed so that coincident requests can
   // only ever produce a single advance.
   assign w_rollover = en && (r_presc == PRESC_TOP);
   assign w_stepEdge = step && !r_stepPrev;
   assign w_advance  = w_rollover || w_stepEdge;

   // Next position, direction and wrap flag for the coming edge. Ping-pong
   // first forces the travel direction inward at an endpoint, which both
   // keeps endpoints from repeating and repairs a stale dir left behind by
   // an up/down phase. The only way to land on 0 in ping-pong is 1 -> 0,
   // so landing on 0 is the wrap condition there.
   always_comb begin
      w_posNext  = r_pos;
      w_dirNext  = r_dir;
      w_wrapNext = 1'b0;
      w_moveUp   = 1'b0;
      if (w_advance) begin
         case (mode)
            2'b00: begin
               w_wrapNext = (r_pos == LAST);
               w_posNext  = (r_pos == LAST) ? '0 : r_pos + 1'b1;
            end
            2'b01: begin
               w_wrapNext = (r_pos == '0);
               w_posNext  = (r_pos == '0) ? LAST : r_pos - 1'b1;
            end
            2'b10: begin
               if (N_OUT == 1) begin
                  w_wrapNext = 1'b1;
               end else begin
                  w_moveUp = (r_dir == DIR_UP);
                  if (r_pos == LAST) begin
                     w_moveUp = 1'b0;
                  end else if (r_pos == '0) begin
                     w_moveUp = 1'b1;
                  end
                  w_posNext = w_moveUp ? r_pos + 1'b1 : r_pos - 1'b1;
                  if (w_posNext == LAST) begin
                     w_dirNext = DIR_DOWN;
                  end else if (w_posNext == '0) begin
                     w_dirNext = DIR_UP;
                  end else begin
                     w_dirNext = w_moveUp ? DIR_UP : DIR_DOWN;
                  end
                  w_wrapNext = (w_posNext == '0);
               end
            end
            default: begin
            end
         endcase
      end
   end

   // One-hot decode of the next position with the output polarity applied,
   // so out is registered alongside pos and never lags it.
   always_comb begin
      w_outNext = '0;
      for (int i = 0; i < N_OUT; i++) begin
         w_outNext[i] = (w_posNext == PW'(i)) ^ POL;
      end
   end

   // All state and all outputs move together on the edge that consumes an
   // advance request. Reset wins over everything and clears the prescaler,
   // so the first automatic advance after release is a full DIV cycles away.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_presc    <= '0;
         r_stepPrev <= 1'b0;
         r_dir      <= DIR_UP;
         r_pos      <= '0;
         r_out      <= RESET_OUT;
         r_tick     <= 1'b0;
         r_wrap     <= 1'b0;
      end else begin
         if (en) begin
            r_presc <= w_rollover ? '0 : r_presc + 1'b1;
         end
         r_stepPrev <= step;
         r_dir      <= w_dirNext;
         r_pos      <= w_posNext;
         r_out      <= w_outNext;
         r_tick     <= w_rollover;
         r_wrap     <= w_wrapNext;
      end
   end

   assign out  = r_out;
   assign pos  = r_pos;
   assign tick = r_tick;
   assign wrap = r_wrap;

endmodule

// File: tb/tb_led_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for led_sequencer. Three instances share one stimulus stream:
//   A: N_OUT=8, DIV=4, active high
//   B: N_OUT=4, DIV=1, active low
//   C: N_OUT=1, DIV=1, active high
// A behavioural model per instance treats ping-pong as an index walking a
// cycle of length 2*(N_OUT-1), and is compared on every falling edge.
// ---------------------------------------------------------------------------
module tb_led_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [1:0] mode;
   logic       step;

   logic [7:0] outA;
   logic [2:0] posA;
   logic       tickA, wrapA;
   logic [3:0] outB;
   logic [1:0] posB;
   logic       tickB, wrapB;
   logic [0:0] outC;
   logic [0:0] posC;
   logic       tickC, wrapC;

   int checks   = 0;
   int failures = 0;
   bit checkOn  = 1'b0;

   int nCfg[3]  = '{8, 4, 1};
   int dCfg[3]  = '{4, 1, 1};
   int alCfg[3] = '{0, 1, 0};

   int mPos[3]   = '{0, 0, 0};
   int mUp[3]    = '{1, 1, 1};
   int mPresc[3] = '{0, 0, 0};
   int mPrev[3]  = '{0, 0, 0};
   int mTick[3]  = '{0, 0, 0};
   int mWrap[3]  = '{0, 0, 0};

   led_sequencer #(.N_OUT(8), .DIV(4), .ACTIVE_LOW(0)) dutA (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .step(step),
      .out(outA), .pos(posA), .tick(tickA), .wrap(wrapA)
   );

   led_sequencer #(.N_OUT(4), .DIV(1), .ACTIVE_LOW(1)) dutB (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .step(step),
      .out(outB), .pos(posB), .tick(tickB), .wrap(wrapB)
   );

   led_sequencer #(.N_OUT(1), .DIV(1), .ACTIVE_LOW(0)) dutC (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .step(step),
      .out(outC), .pos(posC), .tick(tickC), .wrap(wrapC)
   );

   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Expected out bus for instance d from the model position.
   function automatic int expOut(input int d);
      int o;
      o = 1 << mPos[d];
      if (alCfg[d] != 0) o = o ^ ((1 << nCfg[d]) - 1);
      return o;
   endfunction

   // Model of one clock edge for instance d, from the rules of the block.
   task automatic modelEdge(input int d);
      int n;
      int dv;
      int per;
      int k;
      bit roll;
      bit stepEdge;
      n  = nCfg[d];
      dv = dCfg[d];
      if (rst) begin
         mPos[d] = 0; mUp[d] = 1; mPresc[d] = 0; mPrev[d] = 0;
         mTick[d] = 0; mWrap[d] = 0;
         return;
      end
      roll     = en && (mPresc[d] == dv - 1);
      stepEdge = step && (mPrev[d] == 0);
      mTick[d] = int'(roll);
      mWrap[d] = 0;
      if (en) mPresc[d] = (mPresc[d] + 1) % dv;
      mPrev[d] = int'(step);
      if (roll || stepEdge) begin
         case (mode)
            2'd0: begin
               mWrap[d] = int'(mPos[d] == n - 1);
               mPos[d]  = (mPos[d] + 1) % n;
            end
            2'd1: begin
               mWrap[d] = int'(mPos[d] == 0);
               mPos[d]  = (mPos[d] + n - 1) % n;
            end
            2'd2: begin
               if (n == 1) begin
                  mWrap[d] = 1;
               end else begin
                  per = 2 * (n - 1);
                  k = (mUp[d] != 0) ? mPos[d] : per - mPos[d];
                  k = (k + 1) % per;
                  mPos[d]  = (k < n) ? k : per - k;
                  mUp[d]   = int'(k < n - 1);
                  mWrap[d] = int'(k == 0);
               end
            end
            default: begin
            end
         endcase
      end
   endtask

   // Model advances on the same edge the DUTs sample their inputs.
   always @(posedge clk) begin
      for (int d = 0; d < 3; d++) modelEdge(d);
   end

   // Compare process: all outputs of all instances against the model.
   always @(negedge clk) begin
      if (checkOn) begin
         checkOutput("A.pos",  int'(posA),  mPos[0]);
         checkOutput("A.out",  int'(outA),  expOut(0));
         checkOutput("A.tick", int'(tickA), mTick[0]);
         checkOutput("A.wrap", int'(wrapA), mWrap[0]);
         checkOutput("B.pos",  int'(posB),  mPos[1]);
         checkOutput("B.out",  int'(outB),  expOut(1));
         checkOutput("B.tick", int'(tickB), mTick[1]);
         checkOutput("B.wrap", int'(wrapB), mWrap[1]);
         checkOutput("C.pos",  int'(posC),  mPos[2]);
         checkOutput("C.out",  int'(outC),  expOut(2));
         checkOutput("C.tick", int'(tickC), mTick[2]);
         checkOutput("C.wrap", int'(wrapC), mWrap[2]);
      end
   end

   // Directed scenarios with hand-computed expectations, then random traffic.
   task automatic applyStimulus();
      int pp[7] = '{1, 2, 3, 2, 1, 0, 1};
      int tickCnt;

      rst = 1'b1; en = 1'b0; mode = 2'd0; step = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOn = 1'b1;
      checkOutput("rst.posA", int'(posA), 0);
      checkOutput("rst.outA", int'(outA), 8'h01);
      checkOutput("rst.outB", int'(outB), 4'hE);

      // Up wrap on A: one step every 4 cycles, wrap only on 7 -> 0.
      rst = 1'b0; en = 1'b1; mode = 2'd0;
      for (int c = 1; c <= 36; c++) begin
         @(negedge clk);
         checkOutput("up.posA",  int'(posA),  (c / 4) % 8);
         checkOutput("up.tickA", int'(tickA), int'(c % 4 == 0));
         checkOutput("up.wrapA", int'(wrapA), int'(c == 32));
      end

      // Ping-pong on B at one step per cycle.
      rst = 1'b1; mode = 2'd2;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("pp.posB0", int'(posB), 0);
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         checkOutput("pp.posB",  int'(posB), pp[i]);
         checkOutput("pp.wrapB", int'(wrapB), int'(i == 5));
         checkOutput("pp.outB",  int'(outB), (~(1 << pp[i])) & 4'hF);
      end

      // Held step advances once; step edge with rollover advances once.
      rst = 1'b1; en = 1'b0; mode = 2'd0;
      @(negedge clk);
      rst = 1'b0; step = 1'b1;
      repeat (5) @(negedge clk);
      checkOutput("stepHeld.posA", int'(posA), 1);
      step = 1'b0; en = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("stepPre.posA", int'(posA), 1);
      step = 1'b1;
      @(negedge clk);
      checkOutput("stepRoll.posA", int'(posA), 2);

      // Hold at 3 through three ticks, then switch to down.
      step = 1'b0; en = 1'b0;
      @(negedge clk);
      step = 1'b1;
      @(negedge clk);
      checkOutput("holdSetup.posA", int'(posA), 3);
      step = 1'b0; mode = 2'd3; en = 1'b1; tickCnt = 0;
      repeat (12) begin
         @(negedge clk);
         checkOutput("hold.posA",  int'(posA),  3);
         checkOutput("hold.wrapA", int'(wrapA), 0);
         tickCnt += int'(tickA);
      end
      checkOutput("hold.ticks", tickCnt, 3);
      mode = 2'd1;
      repeat (3) @(negedge clk);
      checkOutput("down.wait.posA", int'(posA), 3);
      @(negedge clk);
      checkOutput("down.posA", int'(posA), 2);

      // Reset mid-run at pos=5, prescaler=2.
      rst = 1'b1; mode = 2'd0;
      @(negedge clk);
      rst = 1'b0;
      repeat (22) @(negedge clk);
      checkOutput("mid.posA", int'(posA), 5);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("midRst.posA", int'(posA), 0);
      checkOutput("midRst.outA", int'(outA), 8'h01);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         checkOutput("midRst.adv.posA", int'(posA), int'(c == 4));
      end

      // Degenerate single-output instance.
      repeat (3) begin
         @(negedge clk);
         checkOutput("deg.posC",  int'(posC),  0);
         checkOutput("deg.outC",  int'(outC),  1);
         checkOutput("deg.tickC", int'(tickC), 1);
         checkOutput("deg.wrapC", int'(wrapC), 1);
      end

      // Random traffic checked by the model only.
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 63) == 0);
         en  = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) step = ~step;
         @(negedge clk);
      end
   endtask

   initial begin
      applyStimulus();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 The block SHALL have parameter N_OUT, default 8: number of one-hot outputs, legal range 1..256.
REQ-002 The block SHALL have parameter DIV, default 12000000: clk cycles per automatic step, legal range >= 1.
REQ-003 The block SHALL have parameter ACTIVE_LOW, default 0: when 1, every bit of out is inverted.
REQ-004 The block SHALL have port clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, width 1: synchronous, active-high reset.
REQ-006 The block SHALL have port en, input, width 1: prescaler run enable.
REQ-007 The block SHALL have port mode, input, width 2: 00 up, 01 down, 10 ping-pong, 11 hold.
REQ-008 The block SHALL have port step, input, width 1: manual advance request, level input, rising-edge detected internally.
REQ-009 The block SHALL have port out, output, width N_OUT: one-hot of pos, polarity set by ACTIVE_LOW.
REQ-010 The block SHALL have port pos, output, width max(1,$clog2(N_OUT)): current position index.
REQ-011 The block SHALL have port tick, output, width 1: one-cycle pulse on each prescaler rollover.
REQ-012 The block SHALL have port wrap, output, width 1: one-cycle pulse on completion of a full sequence cycle.

Function
REQ-013 The prescaler SHALL be width max(1,$clog2(DIV)), SHALL count 0..DIV-1 while en=1, roll over to 0, and hold its value while en=0.
REQ-014 An advance request SHALL occur in any cycle where the prescaler is at DIV-1 with en=1, or where step=1 and the registered previous step=0.
REQ-015 A simultaneous prescaler rollover and step edge SHALL produce exactly one advance.
REQ-016 pos, out, tick and wrap SHALL all be registered and SHALL update on the same clock edge that consumes the advance request, giving 1-cycle latency from request to visible change.
REQ-017 Mode up SHALL advance pos to pos+1, with N_OUT-1 going to 0.
REQ-018 Mode down SHALL advance pos to pos-1, with 0 going to N_OUT-1.
REQ-019 Mode ping-pong SHALL use an internal dir register (reset value up), and the sequence SHALL be 0,1,..,N_OUT-1,N_OUT-2,..,1,0,1..., with endpoints not repeated.
REQ-020 In ping-pong, dir SHALL flip on the advance that lands pos on N_OUT-1 (becomes down) or on 0 (becomes up).
REQ-021 Mode hold SHALL leave pos and dir unchanged on an advance request, while tick still pulses and the prescaler keeps running.
REQ-022 A mode change SHALL take effect on the next advance, and entering ping-pong SHALL use the current dir value.
REQ-023 If entering ping-pong leaves dir pointing past an endpoint (pos=N_OUT-1 with dir=up, or pos=0 with dir=down), the block SHALL reverse dir and move inward.
REQ-024 wrap SHALL pulse in up mode on the N_OUT-1 to 0 transition, in down mode on the 0 to N_OUT-1 transition, and in ping-pong on the 1 to 0 transition.
REQ-025 wrap SHALL never pulse in hold mode.
REQ-026 When N_OUT=1, pos SHALL stay 0, out SHALL stay constant, and wrap SHALL pulse on every non-hold advance.
REQ-027 When DIV=1 and en=1, tick SHALL be high every cycle and pos SHALL advance every cycle.
REQ-028 out SHALL equal (1<<pos), XORed with all-ones when ACTIVE_LOW=1, at all times.
REQ-029 Out-of-range parameter values SHALL be rejected at elaboration.

Reset
REQ-030 When rst=1 at a clock edge, the block SHALL set pos=0, dir=up, prescaler=0, tick=0, wrap=0, the step history register=0, and out=one-hot bit 0 (polarity applied).
REQ-031 rst SHALL have priority over any concurrent advance, step edge or mode change.
REQ-032 Reset asserted mid-sequence SHALL discard the pending prescaler count.
REQ-033 On the first cycle after rst deasserts, the prescaler SHALL start at 0, giving the first auto advance exactly DIV enabled cycles later.

Verification
REQ-034 Up wrap (N_OUT=8, DIV=4, en=1, mode=00, release rst): pos SHALL step 0..7,0 every 4 cycles, tick SHALL pulse every 4th cycle, and wrap SHALL pulse only on the 7 to 0 transition.
REQ-035 Ping-pong (N_OUT=4, DIV=1, mode=10): pos SHALL run 0,1,2,3,2,1,0,1 on consecutive cycles, with wrap high only in the cycle showing 0 after 1.
REQ-036 Step plus tick (en=0, mode=00, step held high 5 cycles): pos SHALL advance exactly once; then, with en=1 and DIV=4, a step rising edge coincident with a rollover SHALL advance pos exactly once.
REQ-037 Hold and mode switch (pos=3 in hold, 3 ticks, then mode=01): pos SHALL stay 3 during the ticks, wrap SHALL stay 0, and the next advance SHALL give pos=2.
REQ-038 Reset mid-run (pos=5, prescaler=2, rst pulsed 1 cycle): the next cycle SHALL show pos=0, out=8'b00000001 (8'b11111110 with ACTIVE_LOW=1), and the next advance SHALL come after exactly DIV cycles.
REQ-039 Degenerate configuration (N_OUT=1, DIV=1, mode=00): pos SHALL stay 0, out SHALL stay 1, and tick and wrap SHALL both be high every cycle.
